// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out handshake bundle for the DCT corner-turn buffer.
// Vectors are packed so that element k sits at index [k].
interface dct_transpose_buffer_if #(
  parameter int DW = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [7:0][DW-1:0]  i_vec;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [7:0][DW-1:0]  t_vec;

  modport master (
    output in_valid, i_vec, out_ready,
    input  in_ready, out_valid, out_last, t_vec
  );

  modport slave (
    input  in_valid, i_vec, out_ready,
    output in_ready, out_valid, out_last, t_vec
  );
endinterface

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 corner-turn memory: rows of a block are written into one bank
// while the previously completed bank is read out column by column.
module dct_transpose_buffer #(
  parameter int DW = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  dct_transpose_buffer_if.slave   bus
);

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [2:0]    wr_row_q,  wr_row_d;
  logic [2:0]    rd_col_q,  rd_col_d;
  logic [1:0]    full_q,    full_d;
  logic [DW-1:0] mem_q [2][8][8];
  logic          in_ready_s;
  logic          out_valid_s;
  logic          wr_acc_s;
  logic          rd_acc_s;

  // reset gates in_ready so nothing is accepted while the buffer is being cleared
  assign in_ready_s  = en & reset & ~full_q[wr_bank_q];
  assign out_valid_s = en & full_q[rd_bank_q];
  assign wr_acc_s    = bus.in_valid & in_ready_s;
  assign rd_acc_s    = out_valid_s & bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_last  = out_valid_s & (rd_col_q == 3'd7);

  // Next-state for the bank pointers, row/column counters and full flags
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    full_d    = full_q;
    if (rd_acc_s) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_col_d = rd_col_q;
    end
    // write and read completion always hit different banks, so both may land
    if (wr_acc_s) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_row_d = wr_row_q;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_col_q  <= 3'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
    end
  end

  // Block storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[wr_bank_q][wr_row_q][k] <= bus.i_vec[k];
      end
    end
  end

  // Column read mux, forced to zero whenever no column is being presented
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      if (out_valid_s) begin
        bus.t_vec[k] = mem_q[rd_bank_q][k][rd_col_q];
      end else begin
        bus.t_vec[k] = '0;
      end
    end
  end

endmodule
